// File: rtl/packed_product_accumulator.sv
// packed_product_accumulator
// Splits the packed product word into signed int16/int8/int4 lanes and sums
// each lane on its own, with saturation, over a group of beats framed by
// in_last. The finished group is held for the result writer until it is taken.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | waiting for the first beat of a group (loads, no add)
// S_ACCUM | adding beats into the lane accumulators until in_last
// S_HOLD  | result presented on out_valid, input stalled until out_ready
module packed_product_accumulator #(
    parameter int ACC_W = 20,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        p,
    input  logic [1:0]         mode,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [8*ACC_W-1:0] acc_out,
    output logic [7:0]         ovf,
    output logic [CNT_W-1:0]   beat_cnt,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              mode_q;
    logic [1:0]              lane_mode;
    logic                    accept;
    logic signed [ACC_W-1:0] acc_q   [8];
    logic signed [ACC_W-1:0] lane    [8];
    logic signed [ACC_W:0]   wide    [8];
    logic signed [ACC_W-1:0] sum_sat [8];
    logic [7:0]              sat_hit;

    assign in_ready = (state_q != S_HOLD);
    assign accept   = in_valid && in_ready;

    // The first beat of a group follows the live mode; later beats use the latched one.
    assign lane_mode = (state_q == S_IDLE) ? mode : mode_q;

    // Lane extraction with sign extension; lanes beyond the mode's count stay 0.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            lane[k] = '0;
        end
        case (lane_mode)
            2'b00: begin
                for (int k = 0; k < 2; k++) begin
                    lane[k] = ACC_W'($signed(p[16*k +: 16]));
                end
            end
            2'b01: begin
                for (int k = 0; k < 4; k++) begin
                    lane[k] = ACC_W'($signed(p[8*k +: 8]));
                end
            end
            default: begin
                for (int k = 0; k < 8; k++) begin
                    lane[k] = ACC_W'($signed(p[4*k +: 4]));
                end
            end
        endcase
    end

    // One extra bit of headroom exposes overflow; clamp toward the sign of the true sum.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            wide[k]    = (ACC_W+1)'(acc_q[k]) + (ACC_W+1)'(lane[k]);
            sat_hit[k] = wide[k][ACC_W] != wide[k][ACC_W-1];
            if (!sat_hit[k]) begin
                sum_sat[k] = wide[k][ACC_W-1:0];
            end else if (wide[k][ACC_W]) begin
                sum_sat[k] = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                sum_sat[k] = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

    // Flatten the lane accumulators onto the output bus.
    always_comb begin
        acc_out = '0;
        for (int k = 0; k < 8; k++) begin
            acc_out[k*ACC_W +: ACC_W] = acc_q[k];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = in_last ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept && in_last) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Accumulators, flags, beat count and the registered out_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= 2'b00;
            ovf       <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        mode_q    <= mode;
                        ovf       <= '0;
                        beat_cnt  <= CNT_W'(1);
                        out_valid <= in_last;
                        for (int k = 0; k < 8; k++) begin
                            acc_q[k] <= lane[k];
                        end
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        ovf       <= ovf | sat_hit;
                        out_valid <= in_last;
                        if (!(&beat_cnt)) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                        for (int k = 0; k < 8; k++) begin
                            acc_q[k] <= sum_sat[k];
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_packed_product_accumulator.sv
// Bench for packed_product_accumulator: directed cases plus randomized groups
// checked against a lane-arithmetic reference model.
module tb_packed_product_accumulator;

    localparam int ACC_W = 20;
    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [31:0]        p;
    logic [1:0]         mode;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic [8*ACC_W-1:0] acc_out;
    logic [7:0]         ovf;
    logic [CNT_W-1:0]   beat_cnt;
    logic               out_valid;
    logic               out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    longint     exp_acc [8];
    bit         exp_ovf [8];
    longint     exp_cnt;
    logic [1:0] exp_mode;

    packed_product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .p         (p),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .acc_out   (acc_out),
        .ovf       (ovf),
        .beat_cnt  (beat_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint dut_lane(input int k);
        logic [ACC_W-1:0] raw;
        raw = acc_out[k*ACC_W +: ACC_W];
        return longint'($signed(raw));
    endfunction

    function automatic longint lane_of(input logic [31:0] pv, input logic [1:0] mv, input int k);
        int     w;
        longint v;
        w = (mv == 2'b00) ? 16 : (mv == 2'b01) ? 8 : 4;
        if (k >= 32 / w) return 0;
        v = longint'((pv >> (k * w)) & ((32'h1 << w) - 1));
        if (v >= (longint'(1) << (w - 1))) v -= (longint'(1) << w);
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            exp_acc[k] = 0;
            exp_ovf[k] = 0;
        end
        exp_cnt  = 0;
        exp_mode = 2'b00;
    endtask

    task automatic model_beat(input logic [31:0] pv, input logic [1:0] mv, input bit first);
        longint hi, lo, s;
        hi = (longint'(1) << (ACC_W - 1)) - 1;
        lo = -(longint'(1) << (ACC_W - 1));
        if (first) begin
            exp_mode = mv;
            exp_cnt  = 1;
            for (int k = 0; k < 8; k++) begin
                exp_acc[k] = lane_of(pv, mv, k);
                exp_ovf[k] = 0;
            end
        end else begin
            if (exp_cnt < 65535) exp_cnt++;
            for (int k = 0; k < 8; k++) begin
                s = exp_acc[k] + lane_of(pv, exp_mode, k);
                if (s > hi) begin s = hi; exp_ovf[k] = 1; end
                if (s < lo) begin s = lo; exp_ovf[k] = 1; end
                exp_acc[k] = s;
            end
        end
    endtask

    function automatic longint exp_ovf_word();
        longint v = 0;
        for (int k = 0; k < 8; k++) if (exp_ovf[k]) v |= (longint'(1) << k);
        return v;
    endfunction

    // Drive one beat, wait (bounded) for acceptance, update the model.
    task automatic beat(input logic [31:0] pv, input logic [1:0] mv, input logic lv,
                        input bit first, input int stall);
        int n;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        p = pv; mode = mv; in_last = lv; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", longint'(in_ready), 1);
        model_beat(pv, mv, first);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk(lv ? "out_valid_after_last" : "out_valid_mid_group", longint'(out_valid), longint'(lv));
    endtask

    task automatic check_result(input string tag);
        for (int k = 0; k < 8; k++) chk($sformatf("%s_lane%0d", tag, k), dut_lane(k), exp_acc[k]);
        chk({tag, "_ovf"}, longint'(ovf), exp_ovf_word());
        chk({tag, "_beat_cnt"}, longint'(beat_cnt), exp_cnt);
        chk({tag, "_out_valid"}, longint'(out_valid), 1);
        chk({tag, "_in_ready"}, longint'(in_ready), 0);
    endtask

    task automatic release_result(input int delay);
        for (int i = 0; i < delay; i++) @(negedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("released_out_valid", longint'(out_valid), 0);
        chk("released_in_ready", longint'(in_ready), 1);
    endtask

    task automatic check_reset_values(input string tag);
        for (int k = 0; k < 8; k++) chk($sformatf("%s_lane%0d", tag, k), dut_lane(k), 0);
        chk({tag, "_ovf"}, longint'(ovf), 0);
        chk({tag, "_beat_cnt"}, longint'(beat_cnt), 0);
        chk({tag, "_out_valid"}, longint'(out_valid), 0);
        chk({tag, "_in_ready"}, longint'(in_ready), 1);
    endtask

    initial begin
        reset = 1'b1; p = '0; mode = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_values("reset");

        // int16 group of three beats
        beat(32'hFFF0_0010, 2'b00, 1'b0, 1'b1, 0);
        beat(32'hFFF0_0010, 2'b00, 1'b0, 1'b0, 0);
        beat(32'hFFF0_0010, 2'b00, 1'b1, 1'b0, 0);
        chk("int16_lane0_abs", dut_lane(0), 48);
        chk("int16_lane1_abs", dut_lane(1), -48);
        check_result("int16");
        release_result(0);

        // int8 single beat
        beat(32'h7F7F_7F80, 2'b01, 1'b1, 1'b1, 0);
        chk("int8_lane0_abs", dut_lane(0), -128);
        chk("int8_lane3_abs", dut_lane(3), 127);
        check_result("int8");
        release_result(1);

        // int4 with a mode change on the second beat
        beat(32'h8888_7777, 2'b10, 1'b0, 1'b1, 0);
        beat(32'h8888_7777, 2'b00, 1'b1, 1'b0, 0);
        chk("int4_lane0_abs", dut_lane(0), 14);
        chk("int4_lane7_abs", dut_lane(7), -16);
        check_result("int4");
        release_result(0);

        // saturation in lane 0
        for (int i = 0; i < 16; i++) beat(32'h0000_7FFF, 2'b00, 1'b0, i == 0, 0);
        chk("sat_partial_lane0", dut_lane(0), 524272);
        beat(32'h0000_7FFF, 2'b00, 1'b1, 1'b0, 0);
        chk("sat_final_lane0", dut_lane(0), 524287);
        chk("sat_ovf", longint'(ovf), 1);
        chk("sat_cnt", longint'(beat_cnt), 17);
        check_result("sat");
        release_result(0);
        beat(32'h0001_0001, 2'b00, 1'b1, 1'b1, 0);
        chk("sat_followup_ovf", longint'(ovf), 0);
        check_result("sat_next");

        // backpressure: result held while in_valid stays high
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_last = 1'b1; p = $urandom; mode = 2'($urandom);
            @(posedge clk);
            #1;
            check_result($sformatf("bp%0d", i));
        end
        release_result(0);
        beat(32'h0003_0005, 2'b00, 1'b1, 1'b1, 0);
        chk("bp_fresh_lane0", dut_lane(0), 5);
        check_result("bp_fresh");
        release_result(0);

        // asynchronous reset mid-group
        beat(32'h1122_3344, 2'b01, 1'b0, 1'b1, 0);
        beat(32'h1122_3344, 2'b01, 1'b0, 1'b0, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_values("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        beat(32'h0101_0101, 2'b01, 1'b1, 1'b1, 0);
        chk("post_reset_cnt", longint'(beat_cnt), 1);
        check_result("post_reset");
        release_result(0);

        // randomized groups
        for (int g = 0; g < 40; g++) begin
            int         len;
            logic [1:0] gm;
            len = $urandom_range(1, 8);
            gm  = 2'($urandom);
            for (int b = 0; b < len; b++) begin
                logic [31:0] pv;
                pv = ($urandom_range(0, 3) == 0) ? 32'h7FFF_8000 : $urandom;
                beat(pv, (b == 0) ? gm : 2'($urandom), b == len - 1, b == 0, $urandom_range(0, 2));
            end
            check_result($sformatf("rand%0d", g));
            release_result($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/packed_product_accumulator.md
# packed_product_accumulator

Receive side of the packed-multiplier datapath. The block takes the 32-bit packed product word `p` and its `mode` from the arithmetic unit and splits it into signed lanes: 2×int16, 4×int8 or 8×int4. It accumulates each lane independently over a group of beats framed by `in_last`. It then presents the per-lane sums to the downstream writer with a valid/ready handshake. It sits between the arithmetic unit output register and the result buffer.

## Interface
- `ACC_W`, 20: width of each signed lane accumulator; legal range 16..32.
- `CNT_W`, 16: width of the beat counter.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `p` in 32: packed product word.
- `mode` in 2: packing mode.
  - 2'b00: 2 lanes of 16 bits.
  - 2'b01: 4 lanes of 8 bits.
  - 2'b1x: 8 lanes of 4 bits.
- `in_valid` in 1: `p`/`mode`/`in_last` are valid this cycle.
- `in_last` in 1: the beat is the final beat of its group.
- `in_ready` out 1: the block can accept a beat.
- `acc_out` out 8*ACC_W: lane k sum at bits [k*ACC_W +: ACC_W]; lanes not used by the mode read 0.
- `ovf` out 8: per-lane sticky saturation flag for the presented group.
- `beat_cnt` out CNT_W: number of beats in the presented group.
- `out_valid` out 1: the result is held and valid.
- `out_ready` in 1: the downstream side takes the result.

## Operation
- Lane extraction (lane 0 at the LSBs; each lane sign-extended to ACC_W):
  - mode 00: lane k = p[16k+15:16k].
  - mode 01: lane k = p[8k+7:8k].
  - mode 1x: lane k = p[4k+3:4k].
- A beat is accepted when `in_valid && in_ready`.
- States:
  - IDLE: the first accepted beat latches `mode` into `mode_q`, loads lane k into acc[k] (no add), sets `beat_cnt`=1 and clears `ovf`. Go to HOLD if `in_last`, else go to ACCUM.
  - ACCUM: each accepted beat does acc[k] ← sat(acc[k]+lane k) using `mode_q` and `beat_cnt`++. Go to HOLD on `in_last`.
  - HOLD: `out_valid`=1 and `in_ready`=0. When `out_ready` is 1, go to IDLE on the next edge.
- `in_ready` = (state != HOLD).
- The `mode` input is ignored after the first beat of a group; `mode_q` governs the whole group.
- Saturation:
  - Sums clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - A clamp sets `ovf[k]`, which stays set until the next group starts.
- `beat_cnt` saturates at all-ones and does not wrap.
- Lanes above the mode's lane count hold 0 and never set `ovf`.

## Timing
- Reset values: `acc_out`=0, `ovf`=0, `beat_cnt`=0, `out_valid`=0, `in_ready`=1, state=IDLE, `mode_q`=2'b00.
- Latency: a beat with `in_last` accepted at edge N gives `out_valid`=1 and final `acc_out` after edge N. One-beat groups behave the same way.
- Throughput is one beat per cycle inside a group. Between groups there is at least one HOLD cycle, plus one more cycle for the IDLE re-entry.
- While `out_valid`=1 and `out_ready`=0, `acc_out`, `ovf` and `beat_cnt` are stable and `in_valid` is ignored.
- Register all outputs except `in_ready`, which decodes directly from the state register.
- Reset asserted mid-group or in HOLD discards the partial or held result at once. The first beat after deassertion starts a fresh group.
- `in_valid`=0 inside ACCUM is a stall: the accumulators hold and the count is unchanged.

## Test plan
- Basic int16 group:
  - Stimulus: mode 00, `p`=0xFFF0_0010 for 3 beats, `in_last` on the 3rd.
  - Response: lane0=48, lane1=−48, lanes 2–7=0, `beat_cnt`=3, `out_valid` one cycle after the 3rd accept.
- int8 lanes:
  - Stimulus: mode 01, single beat `p`=0x7F7F_7F80 with `in_last`.
  - Response: lane0=−128, lanes 1–3=127, `beat_cnt`=1, `ovf`=0.
- int4 lanes with a mid-group mode change:
  - Stimulus: mode 2'b10, `p`=0x8888_7777 for 2 beats; `mode` driven to 00 on beat 2.
  - Response: lanes 0–3=14, lanes 4–7=−16; `mode_q` stays 2'b10.
- Saturation, ACC_W=20:
  - Stimulus: mode 00, `p`=0x0000_7FFF for 17 beats.
  - Response: after 16 beats lane0=524272; final lane0=524287, `ovf[0]`=1, `ovf[7:1]`=0, `beat_cnt`=17.
  - Follow-up: the next group clears `ovf`.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles after a result is presented, with `in_valid`=1 throughout.
  - Response: `in_ready`=0, outputs stable, no beats accepted. On the `out_ready` pulse the block returns to IDLE and the next beat starts a fresh sum.
- Reset mid-group:
  - Stimulus: assert `reset` asynchronously after 2 beats of a mode 01 group.
  - Response: all outputs go to reset values immediately. A following single beat of 0x0101_0101 with `in_last` gives lanes 0–3=1 and `beat_cnt`=1.
